// File: rtl/coin_acceptor_pkg.sv
// Shared types and widths for the coin acceptor front end.
package coin_acceptor_pkg;

  typedef enum logic [2:0] {IDLE, MEASURE, EMIT, HOLDOFF, JAM} state_t;

  localparam int DEF_MIN_CYC  = 4;
  localparam int DEF_MAX_CYC  = 1000;
  localparam int DEF_HOLD_CYC = 8;

  localparam int COIN_CNT_W = 8;

  function automatic int cnt_width(input int max_cyc);
    return $clog2(max_cyc + 1);
  endfunction

  // hold only ever holds HOLD_CYC-1
  function automatic int hold_width(input int hold_cyc);
    return (hold_cyc > 1) ? $clog2(hold_cyc) : 1;
  endfunction

  localparam int CNT_W  = cnt_width(DEF_MAX_CYC);
  localparam int HOLD_W = hold_width(DEF_HOLD_CYC);

endpackage

// File: rtl/coin_acceptor_sync2.sv
// Generic 2-flop synchronizer, async active-low reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin sensor front end: sync, pulse-length validation, classification, holdoff.
// Optional stuck-sensor detection built with COIN_ACCEPTOR_JAM_DETECT_EN.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int MIN_CYC  = DEF_MIN_CYC,
  parameter int MAX_CYC  = DEF_MAX_CYC,
  parameter int HOLD_CYC = DEF_HOLD_CYC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sense_a,
  input  logic                  sense_b,
  output logic                  i,
  output logic                  j,
  output logic                  reject,
  output logic                  jam,
  output logic [COIN_CNT_W-1:0] coin_cnt
);

  localparam int CW = cnt_width(MAX_CYC);
  localparam int HW = hold_width(HOLD_CYC);

  logic [1:0] raw, s_sync;
  logic       sa_sync, sb_sync, s_any;

  assign raw = {sense_b, sense_a};

  for (genvar g = 0; g < 2; g++) begin : g_sync
    sync2 u_sync (.clk(clk), .rst(rst), .d(raw[g]), .q(s_sync[g]));
  end

  assign sa_sync = s_sync[0];
  assign sb_sync = s_sync[1];
  assign s_any   = sa_sync | sb_sync;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic          seen_a, seen_b;
  logic [CW-1:0] cnt_inc;
  logic          coin_ok;

  assign cnt_inc = (cnt == CW'(MAX_CYC)) ? cnt : cnt + 1'b1;
  assign coin_ok = (cnt >= CW'(MIN_CYC)) && (seen_a ^ seen_b);

`ifndef COIN_ACCEPTOR_JAM_DETECT_EN
  assign jam = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hold     <= '0;
      seen_a   <= 1'b0;
      seen_b   <= 1'b0;
      i        <= 1'b0;
      j        <= 1'b0;
      reject   <= 1'b0;
      coin_cnt <= '0;
`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
      jam      <= 1'b0;
`endif
    end else begin
      i      <= 1'b0;
      j      <= 1'b0;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (s_any) begin
            state  <= MEASURE;
            cnt    <= CW'(1);
            seen_a <= sa_sync;
            seen_b <= sb_sync;
          end
        end
        MEASURE: begin
          if (s_any) begin
            cnt    <= cnt_inc;
            seen_a <= seen_a | sa_sync;
            seen_b <= seen_b | sb_sync;
`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
            if (cnt_inc == CW'(MAX_CYC)) begin
              state <= JAM;
              jam   <= 1'b1;
            end
`endif
          end else begin
            // Event outputs are registered on entry so they are live during EMIT.
            state <= EMIT;
            if (coin_ok) begin
              i        <= 1'b1;
              j        <= seen_b;
              coin_cnt <= coin_cnt + 1'b1;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        EMIT: begin
          state <= HOLDOFF;
          hold  <= HW'(HOLD_CYC - 1);
        end
        HOLDOFF: begin
          if (hold != '0)
            hold <= hold - 1'b1;
          else if (!s_any)
            state <= IDLE;
        end
`ifdef COIN_ACCEPTOR_JAM_DETECT_EN
        JAM: begin
          if (!s_any) begin
            state <= HOLDOFF;
            hold  <= HW'(HOLD_CYC - 1);
            jam   <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
